// File: rtl/ring_johnson_counter_if.sv
// Control and status bundle for ring_johnson_counter.
// The master drives the controls and the slave returns the counter state.
interface ring_johnson_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             mode;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] out;
  logic             tc;
  logic             err;

  modport master (
    output en, mode, dir, load, load_val,
    input  out, tc, err
  );

  modport slave (
    input  en, mode, dir, load, load_val,
    output out, tc, err
  );
endinterface

// File: rtl/ring_johnson_counter.sv
// Parametrised ring / Johnson shift-register sequencer with bidirectional shift,
// parallel load, illegal-state detection with optional self-correction, and a wrap pulse.
module ring_johnson_counter #(
  parameter int               WIDTH        = 4,
  parameter logic [WIDTH-1:0] RESET_VAL    = WIDTH'(1),
  parameter int               SELF_CORRECT = 1
) (
  input  logic                  CLK,
  input  logic                  CLR,
  ring_johnson_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] out_q, out_d;
  logic             tc_q, tc_d;

  logic [WIDTH-1:0] dec_q, inc_q, inv_q, inc_inv_q;
  logic             one_hot, thermo_lo, thermo_hi, err;
  logic             fb_msb, fb_lsb;
  logic [WIDTH-1:0] shift_up, shift_dn, shifted;

  // x & (x-1) clears the lowest set bit; x & (x+1) is zero only for 0..01..1.
  assign dec_q     = out_q - ONE;
  assign inc_q     = out_q + ONE;
  assign inv_q     = ~out_q;
  assign inc_inv_q = inv_q + ONE;

  assign one_hot   = (out_q != '0) && ((out_q & dec_q) == '0);
  assign thermo_lo = ((out_q & inc_q) == '0);
  assign thermo_hi = ((inv_q & inc_inv_q) == '0);

  assign err = bus.mode ? !(thermo_lo || thermo_hi) : !one_hot;

  assign fb_msb   = bus.mode ? ~out_q[WIDTH-1] : out_q[WIDTH-1];
  assign fb_lsb   = bus.mode ? ~out_q[0]       : out_q[0];
  assign shift_up = {out_q[WIDTH-2:0], fb_msb};
  assign shift_dn = {fb_lsb, out_q[WIDTH-1:1]};
  assign shifted  = bus.dir ? shift_dn : shift_up;

  always_comb begin
    out_d = out_q;
    tc_d  = 1'b0;
    if (bus.load) begin
      out_d = bus.load_val;
    end else if (bus.en && err && (SELF_CORRECT != 0)) begin
      out_d = RESET_VAL;
    end else if (bus.en) begin
      out_d = shifted;
      tc_d  = (shifted == RESET_VAL);
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      out_q <= RESET_VAL;
      tc_q  <= 1'b0;
    end else begin
      out_q <= out_d;
      tc_q  <= tc_d;
    end
  end

  assign bus.out = out_q;
  assign bus.tc  = tc_q;
  assign bus.err = err;

endmodule

// File: tb/tb_ring_johnson_counter.sv
// Bench for ring_johnson_counter: directed literal sequences plus randomized
// stimulus compared every cycle against an arithmetic model, with and without self-correction.
module tb_ring_johnson_counter;
  localparam int W = 4;
  localparam logic [W-1:0] RV = 4'b0001;

  logic CLK = 1'b0;
  logic CLR = 1'b1;
  logic clk_run = 1'b0;

  logic         en = 0, mode = 0, dir = 0, load = 0;
  logic [W-1:0] load_val = '0;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  logic [W-1:0] m_out_a = RV, m_out_b = RV;
  logic         m_tc_a = 0, m_tc_b = 0;

  ring_johnson_counter_if #(.WIDTH(W)) ia ();
  ring_johnson_counter_if #(.WIDTH(W)) ib ();

  assign ia.en = en;  assign ia.mode = mode;  assign ia.dir = dir;
  assign ia.load = load;  assign ia.load_val = load_val;
  assign ib.en = en;  assign ib.mode = mode;  assign ib.dir = dir;
  assign ib.load = load;  assign ib.load_val = load_val;

  ring_johnson_counter #(.WIDTH(W), .RESET_VAL(RV), .SELF_CORRECT(1)) dut_a (
    .CLK(CLK), .CLR(CLR), .bus(ia.slave));
  ring_johnson_counter #(.WIDTH(W), .RESET_VAL(RV), .SELF_CORRECT(0)) dut_b (
    .CLK(CLK), .CLR(CLR), .bus(ib.slave));

  initial begin
    wait (clk_run);
    forever #5 CLK = ~CLK;
  end

  function automatic bit illegal(input logic [W-1:0] x, input logic m);
    int ones = 0;
    int changes = 0;
    for (int i = 0; i < W; i++) ones += int'(x[i]);
    for (int i = 0; i < W - 1; i++) changes += (x[i] != x[i+1]) ? 1 : 0;
    return m ? (changes > 1) : (ones != 1);
  endfunction

  function automatic void model_edge(input bit sc, inout logic [W-1:0] st, output logic t);
    int v;
    int fb;
    v = int'(st);
    t = 1'b0;
    if (load) begin
      st = load_val;
    end else if (en && sc && illegal(st, mode)) begin
      st = RV;
    end else if (en) begin
      if (!dir) begin
        fb = (v >> (W - 1)) & 1;
        if (mode) fb = fb ^ 1;
        v = ((v << 1) & ((1 << W) - 1)) | fb;
      end else begin
        fb = v & 1;
        if (mode) fb = fb ^ 1;
        v = (v >> 1) | (fb << (W - 1));
      end
      st = v[W-1:0];
      t  = (st == RV);
    end
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic e, input logic m, input logic d, input logic l,
                      input logic [W-1:0] lv);
    @(negedge CLK);
    #1;
    en = e; mode = m; dir = d; load = l; load_val = lv;
    @(posedge CLK);
    #1;
    model_edge(1'b1, m_out_a, m_tc_a);
    model_edge(1'b0, m_out_b, m_tc_b);
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      check("cyc_out_a", ia.out, m_out_a);
      check("cyc_tc_a",  W'(ia.tc), W'(m_tc_a));
      check("cyc_err_a", W'(ia.err), W'(illegal(m_out_a, mode)));
      check("cyc_out_b", ib.out, m_out_b);
      check("cyc_tc_b",  W'(ib.tc), W'(m_tc_b));
      check("cyc_err_b", W'(ib.err), W'(illegal(m_out_b, mode)));
    end
  end

  logic [W-1:0] ring_up [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [W-1:0] john_up [8] = '{4'b0011, 4'b0111, 4'b1111, 4'b1110,
                                4'b1100, 4'b1000, 4'b0000, 4'b0001};

  initial begin
    // Reset before any clock edge
    #2 CLR = 1'b0;
    #1;
    check("rst_out", ia.out, 4'b0001);
    check("rst_tc",  W'(ia.tc), '0);
    check("rst_err", W'(ia.err), '0);
    #2 CLR = 1'b1;
    m_out_a = RV; m_out_b = RV; m_tc_a = 0; m_tc_b = 0;
    clk_run = 1'b1;
    chk_en = 1;

    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, '0);
      check("ring_up_out", ia.out, ring_up[i]);
      check("ring_up_tc", W'(ia.tc), (i == 3) ? W'(1) : W'(0));
    end
    step(1, 0, 1, 0, '0);
    check("ring_dn_out0", ia.out, 4'b1000);
    step(1, 0, 1, 0, '0);
    check("ring_dn_out1", ia.out, 4'b0100);

    // Asynchronous clear between edges
    #1 CLR = 1'b0;
    #1;
    check("clr_mid_out", ia.out, 4'b0001);
    check("clr_mid_tc", W'(ia.tc), '0);
    m_out_a = RV; m_out_b = RV; m_tc_a = 0; m_tc_b = 0;
    #1 CLR = 1'b1;
    step(1, 0, 0, 0, '0);
    check("clr_resume", ia.out, 4'b0010);

    step(0, 0, 0, 1, 4'b0001);
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 0, 0, '0);
      check("john_up_out", ia.out, john_up[i]);
      check("john_up_tc", W'(ia.tc), (i == 7) ? W'(1) : W'(0));
    end

    step(0, 0, 0, 1, 4'b0110);
    check("load_ill_out", ia.out, 4'b0110);
    check("load_ill_err", W'(ia.err), W'(1));
    step(1, 0, 0, 0, '0);
    check("corr_out", ia.out, 4'b0001);
    check("corr_err", W'(ia.err), '0);
    check("corr_tc", W'(ia.tc), '0);
    check("nocorr_out", ib.out, 4'b1100);
    check("nocorr_err", W'(ib.err), W'(1));

    step(0, 0, 0, 0, '0);
    check("hold_out", ia.out, 4'b0001);
    step(1, 0, 0, 1, 4'b0100);
    check("load_pri_a", ia.out, 4'b0100);
    check("load_pri_b", ib.out, 4'b0100);

    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 9) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
           ($urandom_range(0, 15) == 0), W'($urandom_range(0, 15)));
    end

    @(negedge CLK);
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
